bist_ctrl: RTL and testbench

Sequencing controller for the built-in self-test datapath: the 5-bit LFSR pattern generator, the combinational circuit under test, and the 4-bit SISR signature compactor. On a start request it reseeds the LFSR, clears the SISR, enables both for a fixed number of pattern cycles, then compares the final signature against a golden value and reports pass/fail. It is the only block that drives the LFSR/SISR control strobes; the datapath registers themselves stay outside.

---
 rtl/bist_pkg.sv | 28 ++
 rtl/bist_ctrl_if.sv | 46 ++++
 rtl/bist_patcnt.sv | 37 +++
 rtl/bist_ctrl.sv | 103 ++++++++++
 tb/tb_bist_ctrl.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/bist_pkg.sv
// bist_pkg: shared types and constants for the BIST sequencing slice.
//   - bist_state_e : controller state encoding
//   - SIG_W_DEF    : default SISR signature width
//   - LFSR_W       : pattern generator width
//   - FAILCNT_W    : failed-run counter width
//   - LFSR_SEED    : nonzero seed the generator loads on seed_ld
//   - cnt_width()  : minimum counter width able to hold a value n
package bist_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SEED  = 3'd1,
      ST_RUN   = 3'd2,
      ST_CHECK = 3'd3,
      ST_DONE  = 3'd4
   } bist_state_e;

   localparam int SIG_W_DEF = 4;
   localparam int LFSR_W    = 5;
   localparam int FAILCNT_W = 8;

   localparam logic [LFSR_W-1:0] LFSR_SEED = 5'b00001;

   function automatic int cnt_width(input int n);
      return (n < 2) ? 1 : $clog2(n + 1);
   endfunction

endpackage

// File: rtl/bist_ctrl_if.sv
// bist_ctrl_if: request/strobe/status bundle between the BIST controller and
// its environment (requester + LFSR/SISR datapath).
//   master : drives start, abort, sig; observes strobes and status
//   slave  : the controller; drives seed_ld, lfsr_en, sisr_en, busy, done,
//            pass (and fail_cnt when BIST_FAILCNT_EN is defined)
// Macro BIST_FAILCNT_EN adds the fail_cnt signal to both modports.
interface bist_ctrl_if
   import bist_pkg::*;
#(
   parameter int SIG_W = SIG_W_DEF
);

   logic             start;
   logic             abort;
   logic [SIG_W-1:0] sig;
   logic             seed_ld;
   logic             lfsr_en;
   logic             sisr_en;
   logic             busy;
   logic             done;
   logic             pass;
`ifdef BIST_FAILCNT_EN
   logic [FAILCNT_W-1:0] fail_cnt;

   modport master (
      output start, abort, sig,
      input  seed_ld, lfsr_en, sisr_en, busy, done, pass, fail_cnt
   );

   modport slave (
      input  start, abort, sig,
      output seed_ld, lfsr_en, sisr_en, busy, done, pass, fail_cnt
   );
`else
   modport master (
      output start, abort, sig,
      input  seed_ld, lfsr_en, sisr_en, busy, done, pass
   );

   modport slave (
      input  start, abort, sig,
      output seed_ld, lfsr_en, sisr_en, busy, done, pass
   );
`endif

endinterface

// File: rtl/bist_patcnt.sv
// bist_patcnt: pattern-cycle up-counter for the BIST controller.
//   clk, rst_b : clock, async active-low reset (count -> 0)
//   clr        : load zero (wins over en)
//   en         : advance by one
//   tc         : count equals PAT_COUNT-1, i.e. the current enabled cycle
//                is the last pattern cycle
// Width is the minimum that covers PAT_COUNT, so the single step past the
// terminal count never wraps.
module bist_patcnt
   import bist_pkg::*;
#(
   parameter int PAT_COUNT = 31
)(
   input  logic clk,
   input  logic rst_b,
   input  logic clr,
   input  logic en,
   output logic tc
);

   localparam int CNT_W = cnt_width(PAT_COUNT);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= cnt + CNT_W'(1);
      end
   end

   assign tc = (cnt == CNT_W'(PAT_COUNT - 1));

endmodule

// File: rtl/bist_ctrl.sv
// bist_ctrl: sequencing controller for the LFSR -> CUT -> SISR self-test path.
// Reseeds the LFSR and clears the SISR, runs PAT_COUNT pattern cycles, then
// compares the settled signature with GOLDEN_SIG.
//   clk, rst_b : clock, async active-low reset
//   bus        : bist_ctrl_if.slave (start/abort/sig in; strobes, busy,
//                done, pass and optional fail_cnt out)
// Macro BIST_FAILCNT_EN adds a saturating count of failed runs that only
// reset clears.
//
// state | meaning
// IDLE  | waiting for start, all strobes low
// SEED  | seed_ld high one cycle, pattern counter cleared
// RUN   | lfsr_en/sisr_en high, PAT_COUNT cycles
// CHECK | enables low, final signature compared
// DONE  | done high, result held until start or abort
module bist_ctrl
   import bist_pkg::*;
#(
   parameter int               PAT_COUNT  = 31,
   parameter int               SIG_W      = SIG_W_DEF,
   parameter logic [SIG_W-1:0] GOLDEN_SIG = SIG_W'(4'hA)
)(
   input  logic        clk,
   input  logic        rst_b,
   bist_ctrl_if.slave  bus
);

   bist_state_e state, nxt_state;
   logic        last_pat;
   logic        pass_q;
   logic        sig_match;

   bist_patcnt #(
      .PAT_COUNT (PAT_COUNT)
   ) u_patcnt (
      .clk   (clk),
      .rst_b (rst_b),
      .clr   (state == ST_SEED),
      .en    (state == ST_RUN),
      .tc    (last_pat)
   );

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         state <= ST_IDLE;
      end else begin
         state <= nxt_state;
      end
   end

   // abort dominates every state, including a simultaneous start
   always_comb begin
      nxt_state = state;
      if (bus.abort) begin
         nxt_state = ST_IDLE;
      end else begin
         case (state)
            ST_IDLE,
            ST_DONE:  if (bus.start) nxt_state = ST_SEED;
            ST_SEED:  nxt_state = ST_RUN;
            ST_RUN:   if (last_pat) nxt_state = ST_CHECK;
            ST_CHECK: nxt_state = ST_DONE;
            default:  nxt_state = ST_IDLE;
         endcase
      end
   end

   // sig is sampled one cycle after the last sisr_en cycle
   assign sig_match = (bus.sig == GOLDEN_SIG);

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         pass_q <= 1'b0;
      end else if (bus.abort) begin
         pass_q <= 1'b0;
      end else if (state == ST_CHECK) begin
         pass_q <= sig_match;
      end
   end

`ifdef BIST_FAILCNT_EN
   logic [FAILCNT_W-1:0] fail_cnt_q;

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         fail_cnt_q <= '0;
      end else if ((state == ST_CHECK) && !bus.abort && !sig_match
                   && (fail_cnt_q != '1)) begin
         fail_cnt_q <= fail_cnt_q + FAILCNT_W'(1);
      end
   end

   assign bus.fail_cnt = fail_cnt_q;
`endif

   assign bus.seed_ld = (state == ST_SEED);
   assign bus.lfsr_en = (state == ST_RUN);
   assign bus.sisr_en = (state == ST_RUN);
   assign bus.busy    = (state == ST_SEED) || (state == ST_RUN) || (state == ST_CHECK);
   assign bus.done    = (state == ST_DONE);
   assign bus.pass    = pass_q;

endmodule

// File: tb/tb_bist_ctrl.sv
`timescale 1ns/1ps
module tb_bist_ctrl;
   import bist_pkg::*;

   localparam int         PAT  = 31;
   localparam logic [3:0] GOLD = 4'hA;

   typedef struct {
      int         start_e;
      logic       pass;
      logic [7:0] fc;
   } exp_t;

   logic clk   = 1'b0;
   logic rst_b = 1'b0;

   bist_ctrl_if #(.SIG_W(4)) bif ();

   bist_ctrl #(
      .PAT_COUNT  (PAT),
      .SIG_W      (4),
      .GOLDEN_SIG (GOLD)
   ) dut (
      .clk   (clk),
      .rst_b (rst_b),
      .bus   (bif)
   );

   always #5 clk = ~clk;

   int   edge_cnt = 0;
   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   int         vecs  = 0;
   int         fails = 0;
   exp_t       q[$];
   logic       cur_pass = 1'b0;
   logic [7:0] exp_fc   = 8'd0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vecs++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // monitor: counts strobe cycles per run, checks each completed run
   initial begin : monitor
      int   seed_n, run_n, sisr_n;
      logic done_q;
      exp_t e;
      seed_n = 0; run_n = 0; sisr_n = 0; done_q = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_b || (!bif.busy && !bif.done)) begin
            seed_n = 0; run_n = 0; sisr_n = 0;
         end else begin
            seed_n += int'(bif.seed_ld);
            run_n  += int'(bif.lfsr_en);
            sisr_n += int'(bif.sisr_en);
         end
         if (rst_b && bif.done && !done_q) begin
            if (q.size() == 0) begin
               vecs++;
               fails++;
               $display("FAIL sb_underflow: done rose with no run outstanding (t=%0t)", $time);
            end else begin
               e = q.pop_front();
               chk("latency",     edge_cnt - e.start_e, PAT + 2);
               chk("seed_cycles", seed_n, 1);
               chk("run_cycles",  run_n,  PAT);
               chk("sisr_cycles", sisr_n, PAT);
               chk("pass",        bif.pass, e.pass);
`ifdef BIST_FAILCNT_EN
               chk("fail_cnt",    bif.fail_cnt, e.fc);
`endif
            end
            seed_n = 0; run_n = 0; sisr_n = 0;
         end
         done_q = bif.done;
      end
   end

   // one full run; start held for 'hold' sampling edges; called at posedge+1
   task automatic do_run(input logic [3:0] s, input int hold);
      exp_t e;
      bit   got;
      bif.sig   = s;
      bif.start = 1'b1;
      @(posedge clk); #1;
      e.start_e = edge_cnt;
      e.pass    = (s == GOLD);
      if (!e.pass && exp_fc != 8'hFF) exp_fc = exp_fc + 8'd1;
      e.fc = exp_fc;
      q.push_back(e);
      if (hold <= 1) bif.start = 1'b0;
      chk("seed_strobe",    bif.seed_ld, 1);
      chk("pass_hold_seed", bif.pass, cur_pass);
      got = 1'b0;
      for (int c = 1; c <= PAT + 6 && !got; c++) begin
         @(posedge clk); #1;
         if (c + 1 >= hold) bif.start = 1'b0;
         if (c == 10) begin
            chk("run_enable",    bif.lfsr_en, 1);
            chk("pass_hold_run", bif.pass, cur_pass);
         end
         if (bif.done) got = 1'b1;
      end
      chk("done_reached", bif.done, 1);
      cur_pass = e.pass;
   endtask

   initial begin : watchdog
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      bif.start = 1'b0;
      bif.abort = 1'b0;
      bif.sig   = 4'h0;
      #1;
      chk("rst_seed_ld", bif.seed_ld, 0);
      chk("rst_lfsr_en", bif.lfsr_en, 0);
      chk("rst_sisr_en", bif.sisr_en, 0);
      chk("rst_busy",    bif.busy,    0);
      chk("rst_done",    bif.done,    0);
      chk("rst_pass",    bif.pass,    0);
`ifdef BIST_FAILCNT_EN
      chk("rst_fail_cnt", bif.fail_cnt, 0);
`endif
      #12 rst_b = 1'b1;
      @(posedge clk); #1;

      do_run(4'hA, 1);
      do_run(4'h5, 1);
      do_run(4'hA, 1);
      do_run(4'hA, 25);

      // abort during the 10th RUN cycle
      bif.sig   = 4'hA;
      bif.start = 1'b1;
      @(posedge clk); #1;
      bif.start = 1'b0;
      repeat (10) begin @(posedge clk); #1; end
      chk("abort_pre_run", bif.lfsr_en, 1);
      bif.abort = 1'b1;
      @(posedge clk); #1;
      bif.abort = 1'b0;
      chk("abort_lfsr_en", bif.lfsr_en, 0);
      chk("abort_sisr_en", bif.sisr_en, 0);
      chk("abort_busy",    bif.busy,    0);
      chk("abort_done",    bif.done,    0);
      chk("abort_pass",    bif.pass,    0);
      cur_pass = 1'b0;
      @(posedge clk); #1;
      chk("abort_idle_seed", bif.seed_ld, 0);

      // start and abort together in DONE
      do_run(4'hA, 1);
      bif.start = 1'b1;
      bif.abort = 1'b1;
      @(posedge clk); #1;
      bif.start = 1'b0;
      bif.abort = 1'b0;
      chk("sa_done",    bif.done,    0);
      chk("sa_busy",    bif.busy,    0);
      chk("sa_seed_ld", bif.seed_ld, 0);
      chk("sa_pass",    bif.pass,    0);
      cur_pass = 1'b0;
      @(posedge clk); #1;
      chk("sa_no_seed", bif.seed_ld, 0);

      // reset mid-RUN after a passing run
      do_run(4'hA, 1);
      bif.start = 1'b1;
      @(posedge clk); #1;
      bif.start = 1'b0;
      repeat (5) begin @(posedge clk); #1; end
      chk("rr_pre_run", bif.lfsr_en, 1);
      rst_b = 1'b0;
      #1;
      chk("rr_lfsr_en", bif.lfsr_en, 0);
      chk("rr_sisr_en", bif.sisr_en, 0);
      chk("rr_busy",    bif.busy,    0);
      chk("rr_done",    bif.done,    0);
      chk("rr_pass",    bif.pass,    0);
`ifdef BIST_FAILCNT_EN
      chk("rr_fail_cnt", bif.fail_cnt, 0);
`endif
      cur_pass = 1'b0;
      exp_fc   = 8'd0;
      #2 rst_b = 1'b1;
      repeat (5) begin
         @(posedge clk); #1;
         chk("rr_idle_seed", bif.seed_ld, 0);
         chk("rr_idle_busy", bif.busy,    0);
      end

      do_run(4'h5, 1);
      do_run(4'hA, 1);

`ifdef BIST_FAILCNT_EN
      repeat (300) do_run(4'h5, 1);
      chk("fc_saturated", bif.fail_cnt, 8'hFF);
      bif.abort = 1'b1;
      @(posedge clk); #1;
      bif.abort = 1'b0;
      chk("fc_abort_keeps", bif.fail_cnt, 8'hFF);
`endif

      repeat (3) begin @(posedge clk); #1; end
      chk("sb_drain", q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
      $finish;
   end

endmodule
